sap_control_sequencer: RTL and testbench
========================================

// Module: sap_control_sequencer
// PURPOSE
// - Ring-counter control sequencer for the SAP-1 datapath. Sits between the instruction decoder and the datapath.
// - Fetch is T1-T3. Execute is T4-T6, driven by the one-hot decoder strobes.
// - Produces the per-cycle control word: PC, MAR, RAM, IR, ACC, B, ALU, OUT and flags.
// - Latches HALT. Control outputs are combinational from the registered T-state and the strobes.
// PARAMETERS
// - ALU_OP_W  3  width of the alu_op select bus
// PORTS
// - clk          in   1         system clock, rising edge
// - clr_n        in   1         asynchronous active-low reset
// - lda,add,sub,out,xor_ratna,and_ratna,or_ratna,cmp_ratna  in  1 each  decoder strobes
// - lda_imm,sta_imm,add_new  in  1 each  decoder strobes
// - low_halt     in   1         0 = HLT opcode in IR
// - step_req     in   1         single-step advance; exists only with SINGLE_STEP_EN
// - t_state      out  6         one-hot T-state (bit0 = T1); 0 while halted or waiting
// - pc_en,pc_inc,mar_ld,ram_en,ram_we,ir_ld,ir_en  out  1 each  datapath controls
// - acc_ld,acc_en,b_ld,alu_en,flag_ld,out_ld  out  1 each  datapath controls
// - alu_op       out  ALU_OP_W  000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 ADC
// - halted       out  1         HALT state reached
// BEHAVIOUR
// - Reset (clr_n low, asynchronous):
//   - state = T1, t_state = 6'b000001, halted = 0.
//   - All control outputs forced to 0 while clr_n is low; alu_op = 000.
// - States: T1..T6 ring, plus HALT (and WAIT with the macro).
//   - Advance once per clk. T6 -> T1.
//   - HALT is absorbing until clr_n.
// - Fetch, identical for every opcode:
//   - T1: pc_en, mar_ld.
//   - T2: pc_inc.
//   - T3: ram_en, ir_ld.
// - Strobes are valid only from T4, since the IR loads at the end of T3. They are ignored in T1-T3.
// - Execute, per opcode (unlisted cycles = all controls 0):
//   - LDA: T4 ir_en+mar_ld; T5 ram_en+acc_ld.
//   - ADD/SUB/XOR/AND/OR/ADD_NEW: T4 ir_en+mar_ld; T5 ram_en+b_ld; T6 alu_en+acc_ld+flag_ld, alu_op per opcode (ADD_NEW = 101).
//   - CMP: T4/T5 as ADD; T6 flag_ld only, alu_op = 001, no acc_ld.
//   - LDA_IMM: T4 ir_en+acc_ld (IR operand nibble zero-extended into ACC).
//   - STA_IMM: T4 ir_en+mar_ld; T5 acc_en+ram_we.
//   - OUT: T4 acc_en+out_ld.
//   - No strobe active: NOP, T4-T6 all 0, ring continues.
// - HLT: low_halt = 0 in T4 -> next edge enters HALT.
//   - t_state = 0, all controls 0, halted = 1.
//   - No control is asserted during the T4 in which HLT is seen.
// - Multiple strobes active (illegal decode): priority HLT > LDA > LDA_IMM > STA_IMM > OUT > CMP > ADD > SUB > XOR > AND > OR > ADD_NEW. Only the winner's controls are driven.
// - Mutual exclusion guaranteed every cycle:
//   - at most one of pc_en/ir_en/acc_en/ram_en drives the bus;
//   - ram_we never coincides with ram_en.
// - Reset mid-instruction: aborts immediately. The next instruction is fetched from T1 after release. Release is synchronous to the first clk edge after clr_n rises.
// CONFIGURATION
// - SINGLE_STEP_EN undefined: step_req absent; T6 -> T1 unconditionally.
// - SINGLE_STEP_EN defined:
//   - T6 -> WAIT. WAIT: t_state = 0, all controls 0.
//   - WAIT -> T1 on the edge where step_req = 1. step_req is level-sampled; held high = free run.
//   - HALT takes priority over WAIT; step_req is ignored in HALT.
//   - Reset still returns to T1, not WAIT.
// TESTING
// - Reset: clr_n=0 for 2 clk, release -> t_state 000001, pc_en=mar_ld=1, halted=0; next edge t_state 000010, pc_inc=1.
// - LDA (lda=1) over 6 clk -> T4 ir_en+mar_ld, T5 ram_en+acc_ld, T6 all 0, then back to T1.
// - SUB -> T6 alu_en=acc_ld=flag_ld=1, alu_op=001. CMP -> T6 flag_ld=1, acc_ld=0, alu_op=001.
// - low_halt=0 at T4 -> next edge halted=1, t_state=0, all controls 0 for 20 clk; clr_n pulse -> T1.
// - lda=1 and out=1 together at T4 -> only ir_en+mar_ld; out_ld stays 0.
// - SINGLE_STEP_EN, step_req=0 after T6 -> held in WAIT 5 clk; step_req=1 one clk -> T1 next edge.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - SAP-1 ring-counter control sequencer (fetch T1-T3, execute T4-T6, HALT)
// Optional single-step WAIT state: define SINGLE_STEP_EN.
module sap_control_sequencer #(
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                lda,
  input  logic                add,
  input  logic                sub,
  input  logic                out,
  input  logic                xor_ratna,
  input  logic                and_ratna,
  input  logic                or_ratna,
  input  logic                cmp_ratna,
  input  logic                lda_imm,
  input  logic                sta_imm,
  input  logic                add_new,
`ifdef SINGLE_STEP_EN
  input  logic                step_req,
`endif
  input  logic                low_halt,
  output logic [5:0]          t_state,
  output logic                pc_en,
  output logic                pc_inc,
  output logic                mar_ld,
  output logic                ram_en,
  output logic                ram_we,
  output logic                ir_ld,
  output logic                ir_en,
  output logic                acc_ld,
  output logic                acc_en,
  output logic                b_ld,
  output logic                alu_en,
  output logic                flag_ld,
  output logic                out_ld,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted
);

  typedef enum logic [2:0] {S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_WAIT} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_HLT, OP_LDA, OP_LDI, OP_STI, OP_OUT, OP_CMP,
    OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_ADC
  } op_t;

  localparam int C_PC_EN   = 12;
  localparam int C_PC_INC  = 11;
  localparam int C_MAR_LD  = 10;
  localparam int C_RAM_EN  = 9;
  localparam int C_RAM_WE  = 8;
  localparam int C_IR_LD   = 7;
  localparam int C_IR_EN   = 6;
  localparam int C_ACC_LD  = 5;
  localparam int C_ACC_EN  = 4;
  localparam int C_B_LD    = 3;
  localparam int C_ALU_EN  = 2;
  localparam int C_FLAG_LD = 1;
  localparam int C_OUT_LD  = 0;

  state_t                state, state_nxt;
  op_t                   op;
  logic                  is_alu;
  logic [ALU_OP_W-1:0]   alu_sel;
  logic [12:0]           ctrl;
  logic [ALU_OP_W-1:0]   alu_op_raw;
  logic                  halted_raw;

  // Priority resolution of an illegal multi-strobe decode; HLT always wins.
  always_comb begin
    op = OP_NOP;
    if (!low_halt)      op = OP_HLT;
    else if (lda)       op = OP_LDA;
    else if (lda_imm)   op = OP_LDI;
    else if (sta_imm)   op = OP_STI;
    else if (out)       op = OP_OUT;
    else if (cmp_ratna) op = OP_CMP;
    else if (add)       op = OP_ADD;
    else if (sub)       op = OP_SUB;
    else if (xor_ratna) op = OP_XOR;
    else if (and_ratna) op = OP_AND;
    else if (or_ratna)  op = OP_OR;
    else if (add_new)   op = OP_ADC;
  end

  always_comb begin
    is_alu  = 1'b1;
    alu_sel = '0;
    case (op)
      OP_ADD:  alu_sel = ALU_OP_W'(0);
      OP_SUB:  alu_sel = ALU_OP_W'(1);
      OP_XOR:  alu_sel = ALU_OP_W'(2);
      OP_AND:  alu_sel = ALU_OP_W'(3);
      OP_OR:   alu_sel = ALU_OP_W'(4);
      OP_ADC:  alu_sel = ALU_OP_W'(5);
      default: is_alu  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= S_T1;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    t_state    = 6'b000000;
    ctrl       = '0;
    alu_op_raw = '0;
    halted_raw = 1'b0;
    case (state)
      S_T1: begin
        t_state = 6'b000001;
        ctrl[C_PC_EN]  = 1'b1;
        ctrl[C_MAR_LD] = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        t_state = 6'b000010;
        ctrl[C_PC_INC] = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        t_state = 6'b000100;
        ctrl[C_RAM_EN] = 1'b1;
        ctrl[C_IR_LD]  = 1'b1;
        state_nxt = S_T4;
      end
      S_T4: begin
        t_state = 6'b001000;
        state_nxt = (op == OP_HLT) ? S_HALT : S_T5;
        if (op == OP_LDA || op == OP_STI || op == OP_CMP || is_alu) begin
          ctrl[C_IR_EN]  = 1'b1;
          ctrl[C_MAR_LD] = 1'b1;
        end else if (op == OP_LDI) begin
          ctrl[C_IR_EN]  = 1'b1;
          ctrl[C_ACC_LD] = 1'b1;
        end else if (op == OP_OUT) begin
          ctrl[C_ACC_EN] = 1'b1;
          ctrl[C_OUT_LD] = 1'b1;
        end
      end
      S_T5: begin
        t_state = 6'b010000;
        state_nxt = S_T6;
        if (op == OP_LDA) begin
          ctrl[C_RAM_EN] = 1'b1;
          ctrl[C_ACC_LD] = 1'b1;
        end else if (op == OP_STI) begin
          ctrl[C_ACC_EN] = 1'b1;
          ctrl[C_RAM_WE] = 1'b1;
        end else if (op == OP_CMP || is_alu) begin
          ctrl[C_RAM_EN] = 1'b1;
          ctrl[C_B_LD]   = 1'b1;
        end
      end
      S_T6: begin
        t_state = 6'b100000;
`ifdef SINGLE_STEP_EN
        state_nxt = S_WAIT;
`else
        state_nxt = S_T1;
`endif
        // CMP runs the subtractor only to update flags; ACC is left untouched.
        if (op == OP_CMP) begin
          ctrl[C_FLAG_LD] = 1'b1;
          alu_op_raw = ALU_OP_W'(1);
        end else if (is_alu) begin
          ctrl[C_ALU_EN]  = 1'b1;
          ctrl[C_ACC_LD]  = 1'b1;
          ctrl[C_FLAG_LD] = 1'b1;
          alu_op_raw = alu_sel;
        end
      end
      S_HALT: halted_raw = 1'b1;
      S_WAIT: begin
`ifdef SINGLE_STEP_EN
        if (step_req) state_nxt = S_T1;
`endif
      end
      default: state_nxt = S_T1;
    endcase
  end

  assign {pc_en, pc_inc, mar_ld, ram_en, ram_we, ir_ld, ir_en,
          acc_ld, acc_en, b_ld, alu_en, flag_ld, out_ld} = ctrl & {13{clr_n}};
  assign alu_op = clr_n ? alu_op_raw : '0;
  assign halted = halted_raw & clr_n;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb/tb_sap_control_sequencer.sv - self-checking bench for sap_control_sequencer
module tb_sap_control_sequencer;

  localparam logic [12:0] PC_EN   = 13'h1000;
  localparam logic [12:0] PC_INC  = 13'h0800;
  localparam logic [12:0] MAR_LD  = 13'h0400;
  localparam logic [12:0] RAM_EN  = 13'h0200;
  localparam logic [12:0] RAM_WE  = 13'h0100;
  localparam logic [12:0] IR_LD   = 13'h0080;
  localparam logic [12:0] IR_EN   = 13'h0040;
  localparam logic [12:0] ACC_LD  = 13'h0020;
  localparam logic [12:0] ACC_EN  = 13'h0010;
  localparam logic [12:0] B_LD    = 13'h0008;
  localparam logic [12:0] ALU_EN  = 13'h0004;
  localparam logic [12:0] FLAG_LD = 13'h0002;
  localparam logic [12:0] OUT_LD  = 13'h0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_n, low_halt;
  logic [10:0] stb;
  logic lda, add, sub, out, xor_ratna, and_ratna, or_ratna, cmp_ratna, lda_imm, sta_imm, add_new;
  logic [5:0]  t_state;
  logic pc_en, pc_inc, mar_ld, ram_en, ram_we, ir_ld, ir_en;
  logic acc_ld, acc_en, b_ld, alu_en, flag_ld, out_ld, halted;
  logic [2:0]  alu_op;
  logic [12:0] act;
`ifdef SINGLE_STEP_EN
  logic        step_req;
`endif

  // strobe index = priority rank (0 highest, after HLT)
  assign {add_new, or_ratna, and_ratna, xor_ratna, sub, add, cmp_ratna, out, sta_imm, lda_imm, lda} = stb;
  assign act = {pc_en, pc_inc, mar_ld, ram_en, ram_we, ir_ld, ir_en, acc_ld, acc_en, b_ld, alu_en, flag_ld, out_ld};

  sap_control_sequencer #(.ALU_OP_W(3)) dut (
    .clk(clk), .clr_n(clr_n),
    .lda(lda), .add(add), .sub(sub), .out(out), .xor_ratna(xor_ratna), .and_ratna(and_ratna),
    .or_ratna(or_ratna), .cmp_ratna(cmp_ratna), .lda_imm(lda_imm), .sta_imm(sta_imm), .add_new(add_new),
`ifdef SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .low_halt(low_halt), .t_state(t_state),
    .pc_en(pc_en), .pc_inc(pc_inc), .mar_ld(mar_ld), .ram_en(ram_en), .ram_we(ram_we), .ir_ld(ir_ld),
    .ir_en(ir_en), .acc_ld(acc_ld), .acc_en(acc_en), .b_ld(b_ld), .alu_en(alu_en), .flag_ld(flag_ld),
    .out_ld(out_ld), .alu_op(alu_op), .halted(halted)
  );

  int checks = 0;
  int errors = 0;
  int m_ts;   // model T-step: 1..6, 0 = halted, 7 = waiting for step

  // Expected control word for one cycle, from the instruction table.
  function automatic void model_ctrl(input int ts, input logic [10:0] s, input logic lh,
                                     output logic [12:0] c, output logic [2:0] op);
    int w;
    c = '0; op = 3'd0; w = -1;
    for (int i = 10; i >= 0; i--) if (s[i]) w = i;
    if (ts == 1) c = PC_EN | MAR_LD;
    else if (ts == 2) c = PC_INC;
    else if (ts == 3) c = RAM_EN | IR_LD;
    else if (ts >= 4 && ts <= 6 && lh && w >= 0) begin
      if (w == 0) c = (ts == 4) ? (IR_EN | MAR_LD) : (ts == 5) ? (RAM_EN | ACC_LD) : 13'h0;
      else if (w == 1) c = (ts == 4) ? (IR_EN | ACC_LD) : 13'h0;
      else if (w == 2) c = (ts == 4) ? (IR_EN | MAR_LD) : (ts == 5) ? (ACC_EN | RAM_WE) : 13'h0;
      else if (w == 3) c = (ts == 4) ? (ACC_EN | OUT_LD) : 13'h0;
      else begin
        c = (ts == 4) ? (IR_EN | MAR_LD) : (ts == 5) ? (RAM_EN | B_LD) : 13'h0;
        if (ts == 6) begin
          c  = (w == 4) ? FLAG_LD : (ALU_EN | ACC_LD | FLAG_LD);
          op = (w == 4) ? 3'd1 : 3'(w - 5);
        end
      end
    end
  endfunction

  function automatic int model_next(input int ts, input logic lh, input logic sr);
    if (ts == 0) return 0;
    if (ts == 4 && !lh) return 0;
`ifdef SINGLE_STEP_EN
    if (ts == 6) return 7;
    if (ts == 7) return sr ? 1 : 7;
`else
    if (ts == 6) return sr ? 1 : 1;
`endif
    return ts + 1;
  endfunction

  function automatic logic [5:0] ts_onehot(input int ts);
    return (ts >= 1 && ts <= 6) ? 6'(1 << (ts - 1)) : 6'd0;
  endfunction

  task automatic do_reset();
    clr_n = 1'b0;
    @(posedge clk); #1;
    clr_n = 1'b1;
    m_ts = 1;
  endtask

  task automatic test_reset();
    stb = '0; low_halt = 1'b1; clr_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (t_state !== 6'b000001 || act !== 13'h0 || alu_op !== 3'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold t_state=%b ctrl=%h alu_op=%0d halted=%b want 000001/0000/0/0", t_state, act, alu_op, halted);
    end
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (t_state !== 6'b000001 || act !== (PC_EN | MAR_LD) || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_t1 t_state=%b ctrl=%h halted=%b want 000001/%h/0", t_state, act, halted, PC_EN | MAR_LD);
    end
    @(negedge clk);
    checks++;
    if (t_state !== 6'b000010 || act !== PC_INC) begin
      errors++;
      $display("FAIL reset_t2 t_state=%b ctrl=%h want 000010/%h", t_state, act, PC_INC);
    end
  endtask

  task automatic test_directed();
    logic [10:0] d_stb [9];
    logic [12:0] d_exp [9][3];
    logic [2:0]  d_op  [9];
    logic [12:0] e;
    d_stb = '{11'h001, 11'h040, 11'h010, 11'h009, 11'h000, 11'h002, 11'h004, 11'h008, 11'h400};
    d_op  = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5};
    d_exp = '{'{IR_EN | MAR_LD, RAM_EN | ACC_LD, 13'h0},
              '{IR_EN | MAR_LD, RAM_EN | B_LD, ALU_EN | ACC_LD | FLAG_LD},
              '{IR_EN | MAR_LD, RAM_EN | B_LD, FLAG_LD},
              '{IR_EN | MAR_LD, RAM_EN | ACC_LD, 13'h0},
              '{13'h0, 13'h0, 13'h0},
              '{IR_EN | ACC_LD, 13'h0, 13'h0},
              '{IR_EN | MAR_LD, ACC_EN | RAM_WE, 13'h0},
              '{ACC_EN | OUT_LD, 13'h0, 13'h0},
              '{IR_EN | MAR_LD, RAM_EN | B_LD, ALU_EN | ACC_LD | FLAG_LD}};
    low_halt = 1'b1;
`ifdef SINGLE_STEP_EN
    step_req = 1'b1;
`endif
    do_reset();
    for (int k = 0; k < 9; k++) begin
      for (int t = 1; t <= 6; t++) begin
        stb = (t >= 4) ? d_stb[k] : 11'($urandom);
        e = (t == 1) ? (PC_EN | MAR_LD) : (t == 2) ? PC_INC : (t == 3) ? (RAM_EN | IR_LD) : d_exp[k][t-4];
        @(negedge clk);
        checks++;
        if (t_state !== 6'(1 << (t - 1)) || act !== e || alu_op !== ((t == 6) ? d_op[k] : 3'd0)) begin
          errors++;
          $display("FAIL directed_%0d_T%0d t_state=%b ctrl=%h alu_op=%0d want ctrl=%h alu_op=%0d",
                   k, t, t_state, act, alu_op, e, (t == 6) ? d_op[k] : 3'd0);
        end
        @(posedge clk); #1;
      end
`ifdef SINGLE_STEP_EN
      @(posedge clk); #1;
`endif
    end
  endtask

  task automatic test_halt();
    low_halt = 1'b1; stb = '0;
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    low_halt = 1'b0; stb = 11'($urandom);
    @(negedge clk);
    checks++;
    if (t_state !== 6'b001000 || act !== 13'h0) begin
      errors++;
      $display("FAIL halt_t4 t_state=%b ctrl=%h want 001000/0000", t_state, act);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      low_halt = 1'($urandom); stb = 11'($urandom);
`ifdef SINGLE_STEP_EN
      step_req = 1'($urandom);
`endif
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || t_state !== 6'b0 || act !== 13'h0 || alu_op !== 3'd0) begin
        errors++;
        $display("FAIL halt_hold_%0d halted=%b t_state=%b ctrl=%h alu_op=%0d want 1/000000/0000/0", i, halted, t_state, act, alu_op);
      end
    end
    @(posedge clk); #1;
    low_halt = 1'b1;
    do_reset();
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || t_state !== 6'b000001 || act !== (PC_EN | MAR_LD)) begin
      errors++;
      $display("FAIL halt_release halted=%b t_state=%b ctrl=%h want 0/000001/%h", halted, t_state, act, PC_EN | MAR_LD);
    end
    @(posedge clk); #1;
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_wait();
    stb = '0; low_halt = 1'b1; step_req = 1'b0;
    do_reset();
    repeat (6) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (t_state !== 6'b0 || act !== 13'h0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold_%0d t_state=%b ctrl=%h halted=%b want 000000/0000/0", i, t_state, act, halted);
      end
      @(posedge clk);
    end
    #1 step_req = 1'b1;
    @(posedge clk); #1;
    step_req = 1'b0;
    @(negedge clk);
    checks++;
    if (t_state !== 6'b000001) begin
      errors++;
      $display("FAIL wait_step t_state=%b want 000001", t_state);
    end
  endtask
`endif

  task automatic test_random();
    logic [10:0] instr;
    logic        lh_i, sr, rst_now;
    logic [12:0] ec;
    logic [2:0]  eo;
    int          r, halt_cnt;
    instr = '0; lh_i = 1'b1; sr = 1'b1; halt_cnt = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst_now = ($urandom_range(0, 99) < 2) || (halt_cnt > 12);
      if (m_ts == 4) begin
        r = $urandom_range(0, 9);
        instr = (r == 0) ? 11'h0 : (r < 8) ? 11'(1 << $urandom_range(0, 10)) : 11'($urandom);
        lh_i  = ($urandom_range(0, 99) >= 6);
      end
      if (m_ts >= 4 && m_ts <= 6) begin
        stb = instr; low_halt = lh_i;
      end else begin
        stb = 11'($urandom); low_halt = 1'($urandom);
      end
      sr = 1'($urandom);
`ifdef SINGLE_STEP_EN
      step_req = sr;
`endif
      clr_n = !rst_now;
      @(negedge clk);
      if (rst_now) begin
        ec = '0; eo = '0;
      end else begin
        model_ctrl(m_ts, stb, low_halt, ec, eo);
      end
      checks++;
      if (act !== ec || alu_op !== eo || t_state !== (rst_now ? 6'b1 : ts_onehot(m_ts)) ||
          halted !== (!rst_now && m_ts == 0)) begin
        errors++;
        $display("FAIL random_%0d ts=%0d stb=%h lh=%b rst=%b t_state=%b ctrl=%h alu_op=%0d halted=%b want ctrl=%h alu_op=%0d",
                 cyc, m_ts, stb, low_halt, rst_now, t_state, act, alu_op, halted, ec, eo);
      end
      checks++;
      if ($countones({pc_en, ir_en, acc_en, ram_en}) > 1 || (ram_we && ram_en)) begin
        errors++;
        $display("FAIL bus_excl_%0d pc_en=%b ir_en=%b acc_en=%b ram_en=%b ram_we=%b want at most one driver, no we with en",
                 cyc, pc_en, ir_en, acc_en, ram_en, ram_we);
      end
      @(posedge clk); #1;
      m_ts = rst_now ? 1 : model_next(m_ts, low_halt, sr);
      halt_cnt = (m_ts == 0) ? halt_cnt + 1 : 0;
      clr_n = 1'b1;
    end
  endtask

  initial begin
    clr_n = 1'b0; low_halt = 1'b1; stb = '0; m_ts = 1;
`ifdef SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    test_reset();
    test_directed();
    test_halt();
`ifdef SINGLE_STEP_EN
    test_wait();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
